// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotating-square control front end.
//   db_state_t : debounce FSM state encoding
//   SPEED_W    : width of the rate-select input
//   EN_RST     : reset value of the run enable
//   UP_RST     : reset value of the direction (1 = clockwise)
package rotate_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int unsigned SPEED_W = 2;

  localparam logic EN_RST = 1'b0;
  localparam logic UP_RST = 1'b1;

endpackage

// File: rtl/db_fsm.sv
// Pushbutton debouncer: a level must hold for 2^DB_W cycles before it is
// accepted. A one-cycle press pulse is issued when a high level is accepted;
// release is silent.
//   clk, rst_n : clock, asynchronous active-low reset
//   sw         : button level (already synchronized, or raw in sim builds)
//   db_level   : registered debounced level
//   press      : registered one-cycle pulse on accepted rising level
module db_fsm #(
  parameter int unsigned DB_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db_level,
  output logic press
);
  import rotate_pkg::*;

  localparam logic [DB_W-1:0] CNT_MAX = '1;

  db_state_t       r_state;
  db_state_t       w_state_nxt;
  logic [DB_W-1:0] r_cnt;
  logic [DB_W-1:0] w_cnt_nxt;
  logic            r_level;
  logic            w_level_nxt;
  logic            r_press;
  logic            w_press_nxt;

  // State, qualification counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Next state; any bounce during qualification drops back to the stable state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_press_nxt = 1'b0;
    case (r_state)
      ZERO: begin
        if (sw) begin
          w_state_nxt = WAIT1;
          w_cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!sw) begin
          w_state_nxt = ZERO;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ONE;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ONE: begin
        if (!sw) begin
          w_state_nxt = WAIT0;
          w_cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (sw) begin
          w_state_nxt = ONE;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ZERO;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ZERO;
      end
    endcase
  end

  assign db_level = r_level;
  assign press    = r_press;

endmodule

// File: rtl/rotate_ctrl.sv
// User-control front end for the rotating-square display. Debounces the
// run/pause and direction buttons into toggled en/up levels and generates a
// rate-selectable step strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_en     : raw run/pause button (toggles en)
//   btn_dir    : raw direction button (toggles up, 1 = clockwise)
//   speed      : rate select, tick period = ((2^TICK_W-1) >> speed) + 1
//   en, up     : registered control levels for rotate_square
//   tick       : registered one-cycle step strobe
// Build option: ROTATE_CTRL_SYNC_EN adds a 2-flop synchronizer per button;
// without it the raw buttons drive the debouncers (simulation only).
module rotate_ctrl
  import rotate_pkg::*;
#(
  parameter int unsigned DB_W   = 20,
  parameter int unsigned TICK_W = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_en,
  input  logic               btn_dir,
  input  logic [SPEED_W-1:0] speed,
  output logic               en,
  output logic               up,
  output logic               tick
);

  localparam logic [TICK_W-1:0] CNT_FULL = '1;

  logic              w_sw_en;
  logic              w_sw_dir;
  logic              w_lvl_en;
  logic              w_lvl_dir;
  logic              w_press_en;
  logic              w_press_dir;
  logic              w_tgl_en;
  logic              w_tgl_dir;
  logic [TICK_W-1:0] w_limit;
  logic [TICK_W-1:0] r_cnt;
  logic              r_en;
  logic              r_up;
  logic              r_tick;

`ifdef ROTATE_CTRL_SYNC_EN
  logic [1:0] r_sync_en;
  logic [1:0] r_sync_dir;

  // Two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_en  <= 2'b00;
      r_sync_dir <= 2'b00;
    end else begin
      r_sync_en  <= {r_sync_en[0], btn_en};
      r_sync_dir <= {r_sync_dir[0], btn_dir};
    end
  end

  assign w_sw_en  = r_sync_en[1];
  assign w_sw_dir = r_sync_dir[1];
`else
  assign w_sw_en  = btn_en;
  assign w_sw_dir = btn_dir;
`endif

  db_fsm #(.DB_W(DB_W)) u_db_en (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (w_sw_en),
    .db_level (w_lvl_en),
    .press    (w_press_en)
  );

  db_fsm #(.DB_W(DB_W)) u_db_dir (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (w_sw_dir),
    .db_level (w_lvl_dir),
    .press    (w_press_dir)
  );

  // A press is only honoured while its debounced level is high
  assign w_tgl_en  = w_press_en & w_lvl_en;
  assign w_tgl_dir = w_press_dir & w_lvl_dir;

  assign w_limit = CNT_FULL >> speed;

  // Control toggles and step counter. >= lets a mid-count speed increase
  // wrap on the next cycle; the tick is suppressed on the edge en turns off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= EN_RST;
      r_up   <= UP_RST;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_en <= r_en ^ w_tgl_en;
      r_up <= r_up ^ w_tgl_dir;
      if (r_en) begin
        if (r_cnt >= w_limit) begin
          r_cnt  <= '0;
          r_tick <= ~w_tgl_en;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign en   = r_en;
  assign up   = r_up;
  assign tick = r_tick;

endmodule

// File: doc/rotate_ctrl.md
# rotate_ctrl

User-control front end for the rotating-square display: debounces the run/pause and direction pushbuttons and produces the `en`/`up` levels consumed by `rotate_square`. It also produces a rate-selectable `tick` step strobe. The block sits directly upstream of `rotate_square` in the board top, between the raw board buttons/switches and the display stage.

## Interface
- `DB_W`, default 20: debounce counter width; a level must be stable for 2^DB_W cycles.
- `TICK_W`, default 26: step-rate counter width.
- `clk` in 1: system clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `btn_en` in 1: raw run/pause pushbutton, asynchronous, bouncy.
- `btn_dir` in 1: raw direction pushbutton, asynchronous, bouncy.
- `speed` in 2: rate select from switches; sampled every cycle.
- `en` out 1: run enable to `rotate_square`.
- `up` out 1: direction to `rotate_square`; 1 = clockwise.
- `tick` out 1: one-cycle step strobe.

## Operation
- Each button path runs synchronizer, then a `db_fsm` instance, then rising-edge pulse `press`.
- `db_fsm` states:
  - ZERO: input 1 -> WAIT1, counter cleared.
  - WAIT1: input 0 -> ZERO. Counter increments while input is 1. When counter == 2^DB_W-1 and input is 1 -> ONE, and `press` is registered high for exactly one cycle.
  - ONE: input 0 -> WAIT0, counter cleared.
  - WAIT0: input 1 -> ONE. Counter == 2^DB_W-1 and input 0 -> ZERO. No pulse on release.
- A bounce inside WAIT1 or WAIT0 returns the FSM to the stable state and restarts qualification from zero.
- `press_en` toggles `en`; `press_dir` toggles `up`. Presses on both buttons in the same cycle toggle both. Holding a button gives one toggle only.
- Step counter `cnt` is TICK_W bits wide, and `limit = (2^TICK_W-1) >> speed`.
- While `en` = 1: if `cnt >= limit`, then `cnt` <= 0 and `tick` <= 1; otherwise `cnt` increments and `tick` <= 0.
- While `en` = 0: `cnt` holds and `tick` = 0.
- `>=` makes a mid-count speed increase (limit below `cnt`) wrap on the next cycle with a single tick. There is no overflow.

## Timing
- Reset values: `en` = 0, `up` = 1, `tick` = 0, `cnt` = 0, both FSMs in ZERO, synchronizer flops 0.
- Asserting `rst_n` low mid-debounce or mid-count returns all state to reset values immediately. Outputs are valid from the first edge after release.
- Button latency, with synchronizer: `en`/`up` toggles at the (2^DB_W+3)-th rising edge after the edge that first samples the stable button high.
- Tick period: `limit`+1 cycles.
- Enable timing: the first tick comes `limit`+1 cycles after `en` rises from `cnt` = 0. After a pause, the count resumes from the held `cnt`.
- `tick` is registered and never asserts in the cycle `en` falls.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ROTATE_CTRL_SYNC_EN` defined: each button passes through a 2-flop synchronizer before `db_fsm`.
- `ROTATE_CTRL_SYNC_EN` undefined: raw buttons feed `db_fsm` directly, and button latency becomes the (2^DB_W+1)-th edge. This form is for simulation only.
- Tick logic is identical in both builds.

## Structure
- Package `rotate_pkg`:
  - enum `db_state_t` {ZERO, WAIT1, ONE, WAIT0}
  - `localparam SPEED_W = 2`
  - reset constants `EN_RST = 0`, `UP_RST = 1`
- Sub-module `db_fsm` (params `DB_W`; ports `clk`, `rst_n`, `sw`, `db_level`, `press`), instantiated twice.
- Synchronizer and tick counter are inline in `rotate_ctrl`.

## Test plan
All scenarios use DB_W=2, TICK_W=4, with the synchronizer compiled in.
- Reset check: hold `rst_n`=0 for 3 cycles -> `en`=0, `up`=1, `tick`=0. Release -> `tick` stays 0 for 50 cycles.
- Clean press: `btn_en` high and held -> `en`=1 exactly 7 edges after the first sampling edge. Holding 40 more cycles -> no further toggle.
- Bounce: `btn_dir` pulses high for 2 cycles, low for 1, then holds high -> `up` toggles to 0 exactly once, 7 edges after the final rise.
- Rate: `en`=1, `speed`=0 -> ticks every 16 cycles. `speed`=3 -> every 2 cycles. Switching 0->3 when `cnt`=9 -> tick on the next cycle, then period 2.
- Pause: tick at cycle T, `en` dropped 5 cycles later and held off 30 cycles -> no ticks. Re-enable -> next tick 11 cycles after re-enable.
- Simultaneous/reset: both buttons pressed in the same cycle -> `en` and `up` toggle on the same edge. `rst_n` pulsed low mid-WAIT1 -> no toggle, outputs return to reset values.
